// File: rtl/if_id_skid_reg.sv
// IF/ID stage register with a two-entry skid buffer, pre-sliced immediates and EXTOp select.
// Define IFID_PERF_CNT_EN to add the stall_cnt / flush_cnt performance counters.
module if_id_skid_reg #(
  parameter int          PC_W      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PC_W-1:0] in_pc,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic [4:0]      out_iimm_shamt,
  output logic [11:0]     out_iimm,
  output logic [11:0]     out_simm,
  output logic [11:0]     out_bimm,
  output logic [19:0]     out_uimm,
  output logic [2:0]      out_ext_op
`ifdef IFID_PERF_CNT_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     flush_cnt
`endif
);

  function automatic logic [2:0] ext_op_sel(input logic [31:0] instr);
    logic [2:0] sel;
    sel = 3'b000;
    case (instr[6:0])
      7'b0010011: sel = (instr[14:12] == 3'b001 || instr[14:12] == 3'b101) ? 3'b011 : 3'b010;
      7'b0000011,
      7'b1100111: sel = 3'b010;
      7'b0100011: sel = 3'b001;
      7'b1100011: sel = 3'b100;
      7'b0110111,
      7'b0010111: sel = 3'b101;
      default:    sel = 3'b000;
    endcase
    return sel;
  endfunction

  logic            h_valid;
  logic            s_valid;
  logic [PC_W-1:0] h_pc;
  logic [PC_W-1:0] s_pc;
  logic [31:0]     h_instr;
  logic [31:0]     s_instr;
  logic            acc;
  logic            pop;
  logic            head_load;

  assign in_ready  = ~s_valid;
  assign out_valid = h_valid;
  assign acc       = in_valid & ~s_valid;
  assign pop       = h_valid & out_ready;
  assign head_load = ~h_valid | pop;

  // Occupancy control: head refills from skid first so order stays FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      h_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (flush) begin
      h_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (head_load) begin
      h_valid <= s_valid | acc;
      s_valid <= s_valid & acc;
    end else if (acc) begin
      s_valid <= 1'b1;
    end
  end

  // Head data; out_pc keeps its last value while the head is empty
  always_ff @(posedge clk) begin
    if (rst) begin
      h_pc <= '0;
    end else if (!flush && head_load) begin
      if (s_valid) begin
        h_pc    <= s_pc;
        h_instr <= s_instr;
      end else if (acc) begin
        h_pc    <= in_pc;
        h_instr <= in_instr;
      end
    end
  end

  // Skid contents only matter once s_valid is set, so load on any accept
  always_ff @(posedge clk) begin
    if (acc) begin
      s_pc    <= in_pc;
      s_instr <= in_instr;
    end
  end

  assign out_pc         = h_pc;
  assign out_instr      = h_valid ? h_instr : NOP_INSTR;
  assign out_iimm_shamt = out_instr[24:20];
  assign out_iimm       = out_instr[31:20];
  assign out_simm       = {out_instr[31:25], out_instr[11:7]};
  assign out_bimm       = {out_instr[31], out_instr[7], out_instr[30:25], out_instr[11:8]};
  assign out_uimm       = out_instr[31:12];
  assign out_ext_op     = ext_op_sel(out_instr);

`ifdef IFID_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (h_valid && !out_ready) stall_cnt <= stall_cnt + 32'd1;
      if (flush)                 flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule
